piso_stream: RTL and testbench
==============================

PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 SHALL have parameter BIT, default 8: word width in bits.
REQ-002 SHALL have parameter NDATA, default 4: buffer depth in words, NDATA >= 2.
REQ-003 SHALL have parameter TAIL, default 0: fill value shifted into vacated slots and driven on o_data when idle.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 emits i_data[0] first; 1 emits i_data[NDATA-1] first.
REQ-005 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_in_valid, input, 1: load request.
REQ-008 SHALL have port o_in_ready, output, 1: load can be accepted.
REQ-009 SHALL have port i_data, input, BIT x NDATA unpacked array [0:NDATA-1]: parallel words.
REQ-010 SHALL have port i_len, input, $clog2(NDATA+1): number of words to emit from this load.
REQ-011 SHALL have port o_out_valid, output, 1: o_data holds a valid word.
REQ-012 SHALL have port i_out_ready, input, 1: consumer accepts o_data.
REQ-013 SHALL have port o_data, output, BIT: current serial word.
REQ-014 SHALL have port o_last, output, 1: o_data is the final word of the current load.
REQ-015 SHALL have port o_busy, output, 1: state is SHIFT.

Function
REQ-016 SHALL implement two states: IDLE (no words pending) and SHIFT (words pending).
REQ-017 SHALL accept a load on the rising edge where i_in_valid && o_in_ready.
REQ-018 SHALL drive o_in_ready = 1 in IDLE and 0 in SHIFT when PISO_STREAM_PRELOAD_EN is undefined.
REQ-019 SHALL, on an accepted load with i_len >= 1, enter SHIFT and present the first word with o_out_valid = 1 in the next cycle (1-cycle latency).
REQ-020 SHALL treat i_len > NDATA as NDATA.
REQ-021 SHALL accept and discard a load with i_len = 0, remaining in IDLE with no output.
REQ-022 SHALL advance one word only on cycles with o_out_valid && i_out_ready, and SHALL hold o_data, o_last and the remaining count stable otherwise.
REQ-023 SHALL shift TAIL into the vacated end of the buffer on each advance.
REQ-024 SHALL assert o_last only while the remaining count equals 1.
REQ-025 SHALL return to IDLE after the o_last word is accepted, unless a preloaded buffer is pending.
REQ-026 SHALL drive o_data = TAIL and o_out_valid = 0 in IDLE.
REQ-027 SHALL give reload priority over advance when both occur in one cycle, which is legal only under PISO_STREAM_PRELOAD_EN.

Reset
REQ-028 SHALL, while i_rst = 1, force state = IDLE, o_out_valid = 0, o_last = 0, o_busy = 0, o_in_ready = 0, o_data = TAIL, count = 0, and all buffers = TAIL.
REQ-029 SHALL assert o_in_ready in the first cycle after i_rst deasserts.
REQ-030 SHALL discard any in-flight words when reset is asserted mid-stream, with no partial output after release.

Configuration
REQ-031 SHALL, when PISO_STREAM_PRELOAD_EN is defined, add a shadow buffer with its own length and drive o_in_ready = !shadow_full.
REQ-032 SHALL, with PISO_STREAM_PRELOAD_EN defined and a load accepted during SHIFT, store that load in the shadow buffer.
REQ-033 SHALL, with PISO_STREAM_PRELOAD_EN defined and the o_last word accepted while the shadow is full, transfer the shadow so its first word is valid in the next cycle with no bubble.
REQ-034 SHALL, without PISO_STREAM_PRELOAD_EN, have no shadow storage and a minimum of one idle cycle between loads.

Structure
REQ-035 SHALL place the state enum (IDLE, SHIFT) and a length-width function in shared package piso_pkg.
REQ-036 SHALL implement the buffer/shift/count datapath as sub-module piso_bank, instantiated once, plus a second instance as the shadow when PISO_STREAM_PRELOAD_EN is defined.

Verification (BIT=8, NDATA=4, TAIL=0, i_data={11,22,33,44} hex)
REQ-037 SHALL cover: MSB_FIRST=0, i_len=4, i_out_ready=1 -> 11,22,33,44 on four consecutive cycles starting the cycle after load, o_last with 44, then IDLE.
REQ-038 SHALL cover: MSB_FIRST=1, i_len=2, i_out_ready toggling 1,0,1 -> 44 (held through stall), then 33 with o_last; o_data=00 afterwards.
REQ-039 SHALL cover: i_len=0 and i_len=7 -> no output for 0; four words for 7 (clamped to 4).
REQ-040 SHALL cover: i_rst pulsed while 22 is presented -> o_out_valid=0 immediately (async), o_in_ready=1 the cycle after release, no further words.
REQ-041 SHALL cover: PISO_STREAM_PRELOAD_EN defined, second load {55,66,77,88} i_len=4 during the first stream -> eight contiguous valid cycles 11..44,55..88, o_last on 44 and on 88.
REQ-042 SHALL cover: PISO_STREAM_PRELOAD_EN undefined, back-to-back i_in_valid -> exactly one cycle with o_out_valid=0 between streams, o_in_ready=0 during SHIFT.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state enum and length-width helper for piso_stream
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a word count able to hold 0..ndata inclusive.
  function automatic int len_w(input int ndata);
    return $clog2(ndata + 1);
  endfunction

endpackage

// File: rtl/piso_bank.sv
// rtl/piso_bank.sv - word buffer held in emission order with shift-out and remaining count
// Priority per cycle: clear, then load, then advance; advance pulls TAIL into the far end.
module piso_bank
  import piso_pkg::*;
#(
  parameter int             BIT   = 8,
  parameter int             NDATA = 4,
  parameter logic [BIT-1:0] TAIL  = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  logic                     i_adv,
  input  logic [BIT-1:0]           i_data [0:NDATA-1],
  input  logic [len_w(NDATA)-1:0]  i_len,
  output logic [BIT-1:0]           o_buf  [0:NDATA-1],
  output logic [len_w(NDATA)-1:0]  o_count
);

  localparam int LW = len_w(NDATA);

  logic [BIT-1:0] buf_q [0:NDATA-1];
  logic [BIT-1:0] buf_d [0:NDATA-1];
  logic [LW-1:0]  count_q;
  logic [LW-1:0]  count_d;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (i_clr) begin
      for (int k = 0; k < NDATA; k++) buf_d[k] = TAIL;
      count_d = '0;
    end else if (i_load) begin
      for (int k = 0; k < NDATA; k++) buf_d[k] = i_data[k];
      count_d = i_len;
    end else if (i_adv && (count_q != '0)) begin
      for (int k = 0; k < NDATA - 1; k++) buf_d[k] = buf_q[k+1];
      buf_d[NDATA-1] = TAIL;
      count_d        = count_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NDATA; k++) buf_q[k] <= TAIL;
      count_q <= '0;
    end else begin
      for (int k = 0; k < NDATA; k++) buf_q[k] <= buf_d[k];
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NDATA; k++) o_buf[k] = buf_q[k];
  end

  assign o_count = count_q;

endmodule

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in serial-out word streamer with valid/ready handshake
// Optional feature macro: PISO_STREAM_PRELOAD_EN (shadow buffer for gapless back-to-back loads).
module piso_stream
  import piso_pkg::*;
#(
  parameter int             BIT       = 8,
  parameter int             NDATA     = 4,
  parameter logic [BIT-1:0] TAIL      = '0,
  parameter bit             MSB_FIRST = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [BIT-1:0]           i_data [0:NDATA-1],
  input  logic [len_w(NDATA)-1:0]  i_len,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [BIT-1:0]           o_data,
  output logic                     o_last,
  output logic                     o_busy
);

  localparam int LW = len_w(NDATA);

  state_e         state_q;
  state_e         state_d;
  logic [BIT-1:0] ordered   [0:NDATA-1];
  logic [BIT-1:0] load_data [0:NDATA-1];
  logic [BIT-1:0] main_buf  [0:NDATA-1];
  logic [LW-1:0]  len_eff;
  logic [LW-1:0]  load_len;
  logic [LW-1:0]  main_count;
  logic           len_nz;
  logic           accept;
  logic           adv;
  logic           last_acc;
  logic           load_main;
  logic           main_load;

  // Banks hold words in emission order, so MSB_FIRST only affects the load path.
  always_comb begin
    for (int k = 0; k < NDATA; k++) begin
      ordered[k] = MSB_FIRST ? i_data[NDATA-1-k] : i_data[k];
    end
  end

  assign len_eff  = (i_len > LW'(NDATA)) ? LW'(NDATA) : i_len;
  assign len_nz   = (len_eff != '0);
  assign accept   = i_in_valid && o_in_ready;
  assign adv      = o_out_valid && i_out_ready;
  assign last_acc = adv && o_last;

  assign o_busy      = (state_q == SHIFT);
  assign o_out_valid = (state_q == SHIFT);
  assign o_last      = (state_q == SHIFT) && (main_count == LW'(1));
  assign o_data      = (state_q == SHIFT) ? main_buf[0] : TAIL;

`ifdef PISO_STREAM_PRELOAD_EN
  logic [BIT-1:0] shadow_buf [0:NDATA-1];
  logic [LW-1:0]  shadow_count;
  logic           shadow_full;
  logic           load_shadow;
  logic           transfer;

  assign shadow_full = (shadow_count != '0);
  assign o_in_ready  = !i_rst && !shadow_full;
  // A load arriving as the last word leaves goes straight to the main bank.
  assign load_main   = accept && len_nz && ((state_q == IDLE) || last_acc);
  assign load_shadow = accept && len_nz && (state_q == SHIFT) && !last_acc;
  assign transfer    = last_acc && shadow_full;
  assign main_load   = load_main || transfer;
  assign load_len    = transfer ? shadow_count : len_eff;

  always_comb begin
    for (int k = 0; k < NDATA; k++) begin
      load_data[k] = transfer ? shadow_buf[k] : ordered[k];
    end
  end

  piso_bank #(
    .BIT   (BIT),
    .NDATA (NDATA),
    .TAIL  (TAIL)
  ) u_shadow (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (transfer),
    .i_load  (load_shadow),
    .i_adv   (1'b0),
    .i_data  (ordered),
    .i_len   (len_eff),
    .o_buf   (shadow_buf),
    .o_count (shadow_count)
  );
`else
  assign o_in_ready = !i_rst && (state_q == IDLE);
  assign load_main  = accept && len_nz;
  assign main_load  = load_main;
  assign load_len   = len_eff;

  always_comb begin
    for (int k = 0; k < NDATA; k++) load_data[k] = ordered[k];
  end
`endif

  piso_bank #(
    .BIT   (BIT),
    .NDATA (NDATA),
    .TAIL  (TAIL)
  ) u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (1'b0),
    .i_load  (main_load),
    .i_adv   (adv),
    .i_data  (load_data),
    .i_len   (load_len),
    .o_buf   (main_buf),
    .o_count (main_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (main_load) state_d = SHIFT;
      SHIFT: if (last_acc && !main_load) state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - scoreboard bench for piso_stream, LSB-first and MSB-first instances
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] data [0:3];
  logic [2:0] len = '0;

  logic       rdy0, val0, last0, busy0;
  logic [7:0] dat0;
  logic       rdy1, val1, last1, busy1;
  logic [7:0] dat1;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  piso_stream #(.BIT(8), .NDATA(4), .TAIL(8'h00), .MSB_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
    .i_data(data), .i_len(len), .o_out_valid(val0), .i_out_ready(out_ready),
    .o_data(dat0), .o_last(last0), .o_busy(busy0)
  );

  piso_stream #(.BIT(8), .NDATA(4), .TAIL(8'h00), .MSB_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1),
    .i_data(data), .i_len(len), .o_out_valid(val1), .i_out_ready(out_ready),
    .o_data(dat1), .o_last(last1), .o_busy(busy1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    data[0] = a; data[1] = b; data[2] = c; data[3] = d;
  endtask

  task automatic test_reset;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rdy0); end
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", val0); end
    checks++; if (last0 !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (dat0 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", dat0); end
    rst = 1'b0;
    tick;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", rdy0); end
  endtask

  task automatic test_lsb_full;
    sb.delete();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    len = 3'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, data[k]});
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (val0 !== (c < 4)) begin errors++; $display("FAIL lsb_valid c=%0d got %b exp %b", c, val0, c < 4); end
      if (val0) begin
        checks++;
        if (sb.size() == 0 || {last0, dat0} !== sb[0]) begin
          errors++; $display("FAIL lsb_word got %h last %b exp %h", dat0, last0, sb.size() ? sb[0] : 9'h0);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      tick;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL lsb_drain got %0d left exp 0", sb.size()); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL lsb_idle got %b exp 0", busy0); end
  endtask

  task automatic test_msb_stall;
    int rp [0:5] = '{0, 1, 0, 1, 1, 1};
    sb.delete();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    len = 3'd2; out_ready = 1'b1; in_valid = 1'b1;
    sb.push_back({1'b0, 8'h44});
    sb.push_back({1'b1, 8'h33});
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      out_ready = rp[c][0];
      checks++;
      if (val1 !== (c < 4)) begin errors++; $display("FAIL msb_valid c=%0d got %b exp %b", c, val1, c < 4); end
      if (val1) begin
        checks++;
        if (sb.size() == 0 || {last1, dat1} !== sb[0]) begin
          errors++; $display("FAIL msb_word got %h last %b exp %h", dat1, last1, sb.size() ? sb[0] : 9'h0);
        end
        if (out_ready && sb.size() != 0) void'(sb.pop_front());
      end
      tick;
    end
    out_ready = 1'b1;
    checks++; if (dat1 !== 8'h00) begin errors++; $display("FAIL msb_tail got %h exp 00", dat1); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL msb_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_len_edge;
    sb.delete();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    out_ready = 1'b1; len = 3'd0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL len0_valid got %b exp 0", val0); end
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL len0_ready got %b exp 1", rdy0); end
      tick;
    end
    len = 3'd7; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, data[k]});
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (val0 !== (c < 4)) begin errors++; $display("FAIL len7_valid c=%0d got %b exp %b", c, val0, c < 4); end
      if (val0) begin
        checks++;
        if (sb.size() == 0 || {last0, dat0} !== sb[0]) begin
          errors++; $display("FAIL len7_word got %h last %b exp %h", dat0, last0, sb.size() ? sb[0] : 9'h0);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      tick;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL len7_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    len = 3'd4; out_ready = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (dat0 !== 8'h22) begin errors++; $display("FAIL rstmid_pre got %h exp 22", dat0); end
    rst = 1'b1;
    #1;
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", val0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", rdy0); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rstmid_release got %b exp 1", rdy0); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL rstmid_flush c=%0d got %b exp 0", c, val0); end
      tick;
    end
  endtask

`ifdef PISO_STREAM_PRELOAD_EN
  task automatic test_preload;
    int loads = 0;
    sb.delete();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    len = 3'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (rdy0 !== !(c >= 2 && c <= 4)) begin errors++; $display("FAIL pre_ready c=%0d got %b", c, rdy0); end
      checks++;
      if (val0 !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL pre_valid c=%0d got %b", c, val0); end
      if (val0) begin
        checks++;
        if (sb.size() == 0 || {last0, dat0} !== sb[0]) begin
          errors++; $display("FAIL pre_word got %h last %b exp %h", dat0, last0, sb.size() ? sb[0] : 9'h0);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (in_valid && rdy0) begin
        loads++;
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, data[k]});
      end
      tick;
      if (loads == 1) set_data(8'h55, 8'h66, 8'h77, 8'h88);
      if (loads == 2) in_valid = 1'b0;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL pre_drain got %0d left exp 0", sb.size()); end
  endtask
`else
  task automatic test_back_to_back;
    int loads = 0;
    sb.delete();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    len = 3'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (val0 !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin
        errors++; $display("FAIL b2b_valid c=%0d got %b", c, val0);
      end
      if (val0) begin
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp 0", c, rdy0); end
        checks++;
        if (sb.size() == 0 || {last0, dat0} !== sb[0]) begin
          errors++; $display("FAIL b2b_word got %h last %b exp %h", dat0, last0, sb.size() ? sb[0] : 9'h0);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (in_valid && rdy0) begin
        loads++;
        for (int k = 0; k < 4; k++) sb.push_back({k == 3, data[k]});
      end
      tick;
      if (loads == 2) in_valid = 1'b0;
    end
    checks++; if (loads != 2) begin errors++; $display("FAIL b2b_loads got %0d exp 2", loads); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left exp 0", sb.size()); end
  endtask
`endif

  initial begin
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_lsb_full();
    test_msb_stall();
    test_len_edge();
    test_reset_mid();
`ifdef PISO_STREAM_PRELOAD_EN
    test_preload();
`else
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
